// File: rtl/contra_pkg.sv
// -----------------------------------------------------------------------------
// contra_pkg
// Shared definitions for the pad reader and the destination-side game logic:
//   - button bit positions inside the 8-bit button word (1 = pressed)
//   - button-word width
//   - gamepad poller FSM state type
// -----------------------------------------------------------------------------
package contra_pkg;

    localparam int BTN_W      = 8;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef enum logic [2:0] {
        GP_IDLE,
        GP_LATCH,
        GP_READ_LO,
        GP_READ_HI,
        GP_DONE
    } gp_state_t;

endpackage

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop single-bit synchronizer. Resets to 1 so an idle (released,
// active-low) pad line reads as "nothing pressed" straight out of reset.
// Ports:
//   clk    in  1  destination clock
//   rst_n  in  1  asynchronous active-low reset
//   d      in  1  asynchronous input
//   q      out 1  synchronized output (2 cycles latency)
// -----------------------------------------------------------------------------
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: async reset belongs in the sensitivity list; state updates use <=
    // so both flops sample the pre-edge values and form a true 2-stage chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gamepad_reader.sv
// -----------------------------------------------------------------------------
// gamepad_reader
// Periodically polls an 8-button NES-style shift-register pad and emits the
// button word to the downstream clock-crossing buffer whenever it changes
// (and unconditionally on the first poll after reset).
// Ports:
//   isrc_clk    in  1  source-domain clock
//   isrc_rst_n  in  1  asynchronous active-low reset
//   igp_data    in  1  pad serial data, asynchronous, active-low
//   ogp_latch   out 1  pad latch strobe, active-high
//   ogp_clk     out 1  pad shift clock, idles high
//   owr         out 1  one-cycle write strobe to the downstream buffer
//   odata       out 8  button word, 1 = pressed (bit order in contra_pkg)
// -----------------------------------------------------------------------------
module gamepad_reader
    import contra_pkg::*;
#(
    parameter int CLK_DIV     = 150,
    parameter int POLL_PERIOD = 416667
) (
    input  logic       isrc_clk,
    input  logic       isrc_rst_n,
    input  logic       igp_data,
    output logic       ogp_latch,
    output logic       ogp_clk,
    output logic       owr,
    output logic [7:0] odata
);

    localparam int HALF_W = $clog2(2 * CLK_DIV);
    localparam int POLL_W = $clog2(POLL_PERIOD);

    localparam logic [HALF_W-1:0] LATCH_LAST = HALF_W'(2 * CLK_DIV - 1);
    localparam logic [HALF_W-1:0] PHASE_LAST = HALF_W'(CLK_DIV - 1);
    localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_PERIOD - 1);

    gp_state_t        state;
    logic [HALF_W-1:0] half_cnt;
    logic [POLL_W-1:0] poll_cnt;
    logic [2:0]        bit_idx;
    logic [BTN_W-1:0]  shift_word;
    logic              first_poll;
    logic              pad_sync;

    sync2 u_sync2 (
        .clk   (isrc_clk),
        .rst_n (isrc_rst_n),
        .d     (igp_data),
        .q     (pad_sync)
    );

    // Free-running poll timebase; a poll starts when it reads 0 in IDLE.
    always_ff @(posedge isrc_clk or negedge isrc_rst_n) begin
        if (!isrc_rst_n) begin
            poll_cnt <= '0;
        end else if (poll_cnt == POLL_LAST) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + 1'b1;
        end
    end

    always_ff @(posedge isrc_clk or negedge isrc_rst_n) begin
        if (!isrc_rst_n) begin
            state      <= GP_IDLE;
            half_cnt   <= '0;
            bit_idx    <= '0;
            shift_word <= '0;
            first_poll <= 1'b1;
            ogp_latch  <= 1'b0;
            ogp_clk    <= 1'b1;
            owr        <= 1'b0;
            odata      <= '0;
        end else begin
            owr <= 1'b0;
            case (state)
                GP_IDLE: begin
                    if (poll_cnt == '0) begin
                        state     <= GP_LATCH;
                        ogp_latch <= 1'b1;
                        half_cnt  <= '0;
                    end
                end
                GP_LATCH: begin
                    if (half_cnt == LATCH_LAST) begin
                        state     <= GP_READ_LO;
                        ogp_latch <= 1'b0;
                        ogp_clk   <= 1'b0;
                        half_cnt  <= '0;
                        bit_idx   <= '0;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                GP_READ_LO: begin
                    if (half_cnt == PHASE_LAST) begin
                        // Sample at the very end of the low phase so the pad
                        // output has settled through the synchronizer.
                        shift_word[bit_idx] <= ~pad_sync;
                        half_cnt            <= '0;
                        ogp_clk             <= 1'b1;
                        state               <= (bit_idx == 3'd7) ? GP_DONE : GP_READ_HI;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                GP_READ_HI: begin
                    if (half_cnt == PHASE_LAST) begin
                        half_cnt <= '0;
                        bit_idx  <= bit_idx + 1'b1;
                        ogp_clk  <= 1'b0;
                        state    <= GP_READ_LO;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                GP_DONE: begin
                    if (shift_word != odata || first_poll) begin
                        odata <= shift_word;
                        owr   <= 1'b1;
                    end
                    first_poll <= 1'b0;
                    state      <= GP_IDLE;
                end
                default: begin
                    state <= GP_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gamepad_reader.sv
// -----------------------------------------------------------------------------
// tb_gamepad_reader
// Directed bench for gamepad_reader with CLK_DIV=4, POLL_PERIOD=200, driving
// a behavioural NES pad (parallel load while latch high, shift on clock rise,
// bit 0 first, active-low). Cycle numbers count rising edges since reset
// release; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_gamepad_reader;

    logic       clk;
    logic       rst_n;
    logic       gp_data;
    logic       gp_latch;
    logic       gp_clk;
    logic       wr;
    logic [7:0] data;

    logic [7:0] pad_word = 8'h00;
    logic [7:0] pad_lvl  = 8'hFF;
    logic       glitch   = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc;

    // Pin-activity monitor counters
    logic prev_clk = 1'b1;
    logic prev_owr = 1'b0;
    int   lo_run   = 0;
    int   hi_run   = 0;
    int   falls    = 0;
    int   bad_lo   = 0;
    int   hi4      = 0;
    int   overlap  = 0;
    int   owr_cnt  = 0;
    int   owr_long = 0;

    int s_falls, s_bad_lo, s_hi4, s_overlap, s_owr;

    gamepad_reader #(
        .CLK_DIV     (4),
        .POLL_PERIOD (200)
    ) dut (
        .isrc_clk   (clk),
        .isrc_rst_n (rst_n),
        .igp_data   (gp_data),
        .ogp_latch  (gp_latch),
        .ogp_clk    (gp_clk),
        .owr        (wr),
        .odata      (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Pad model: stored as line levels (0 = pressed), shifts in released.
    always @(posedge gp_clk or posedge gp_latch) begin
        if (gp_latch) pad_lvl <= ~pad_word;
        else          pad_lvl <= {1'b1, pad_lvl[7:1]};
    end
    assign gp_data = pad_lvl[0] ^ glitch;

    always @(negedge clk) begin
        if (gp_clk !== prev_clk) begin
            if (gp_clk) begin
                if (lo_run != 4) bad_lo++;
            end else begin
                falls++;
                if (hi_run == 4) hi4++;
            end
            lo_run = 0;
            hi_run = 0;
        end
        if (gp_clk) hi_run++;
        else begin
            lo_run++;
            if (gp_latch) overlap++;
        end
        prev_clk = gp_clk;
        if (wr) begin
            owr_cnt++;
            if (prev_owr) owr_long++;
        end
        prev_owr = wr;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic to_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc < n) begin
            @(negedge clk);
            guard++;
            if (guard > 5000) begin
                $display("FAIL to_cyc: cycle %0d never reached (at %0d)", n, cyc);
                $fatal(1, "timeout");
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state and first forced write of an all-released pad
        check("rst_latch", 32'(gp_latch), 32'd0);
        check("rst_clk",   32'(gp_clk),   32'd1);
        check("rst_owr",   32'(wr),       32'd0);
        check("rst_data",  32'(data),     32'h00);
        to_cyc(1);
        check("latch_c1", 32'(gp_latch), 32'd1);
        to_cyc(8);
        check("latch_c8", 32'(gp_latch), 32'd1);
        to_cyc(9);
        check("latch_c9", 32'(gp_latch), 32'd0);
        check("clk_c9",   32'(gp_clk),   32'd0);
        to_cyc(69);
        check("owr_c69", 32'(wr), 32'd0);
        to_cyc(70);
        check("owr_c70",  32'(wr),   32'd1);
        check("data_c70", 32'(data), 32'h00);
        to_cyc(71);
        check("owr_c71", 32'(wr), 32'd0);

        // Right + A held
        pad_word = 8'h81;
        to_cyc(270);
        check("owr_81",  32'(wr),   32'd1);
        check("data_81", 32'(data), 32'h81);
        to_cyc(271);
        s_owr = owr_cnt;

        // Pin sequence over the poll starting at cycle 401
        to_cyc(400);
        s_falls = falls; s_bad_lo = bad_lo; s_hi4 = hi4; s_overlap = overlap;
        to_cyc(480);
        check("low_pulses",   32'(falls - s_falls),     32'd8);
        check("bad_low_len",  32'(bad_lo - s_bad_lo),   32'd0);
        check("shift_rises",  32'(hi4 - s_hi4),         32'd7);
        check("latch_in_low", 32'(overlap - s_overlap), 32'd0);

        to_cyc(680);
        check("no_owr_held", 32'(owr_cnt - s_owr), 32'd0);
        check("data_held",   32'(data),            32'h81);

        // Start only
        pad_word = 8'h08;
        to_cyc(870);
        check("owr_08",  32'(wr),   32'd1);
        check("data_08", 32'(data), 32'h08);
        to_cyc(900);
        check("one_owr_08", 32'(owr_cnt - s_owr), 32'd1);
        s_owr = owr_cnt;

        // One-cycle glitches in LATCH and in bit-0 READ_HI, away from samples
        to_cyc(1003);
        glitch = 1'b1;
        @(negedge clk);
        glitch = 1'b0;
        to_cyc(1014);
        glitch = 1'b1;
        @(negedge clk);
        glitch = 1'b0;
        to_cyc(1100);
        check("glitch_no_owr", 32'(owr_cnt - s_owr), 32'd0);
        check("glitch_data",   32'(data),            32'h08);

        // Reset during READ_HI of bit 3 (poll at 1201, READ_HI b3 = 1237..1240)
        to_cyc(1238);
        check("pre_rst_clk_hi", 32'(gp_clk), 32'd1);
        pad_word = 8'h00;
        rst_n = 1'b0;
        #1;
        check("mid_rst_latch", 32'(gp_latch), 32'd0);
        check("mid_rst_clk",   32'(gp_clk),   32'd1);
        check("mid_rst_owr",   32'(wr),       32'd0);
        check("mid_rst_data",  32'(data),     32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        to_cyc(1);
        check("re_latch_c1", 32'(gp_latch), 32'd1);
        to_cyc(70);
        check("re_owr_c70",  32'(wr),   32'd1);
        check("re_data_c70", 32'(data), 32'h00);
        to_cyc(72);
        check("owr_width", 32'(owr_long), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
